// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion: Pong ball engine.
// It holds the ball at centre while idle, waits out a serve delay, then
// advances the ball once per frame_tick. It also handles wall bounces, paddle
// hits and misses.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous, active-high reset
//   frame_tick_i    one-clk pulse per video frame; motion happens only here
//   ball_velocity_i pixels per frame from the difficulty selector, 0 = off
//   paddle_l_y_i    left paddle top y
//   paddle_r_y_i    right paddle top y
//   ball_x_o        ball top-left x (0..632)
//   ball_y_o        ball top-left y (0..472)
//   ball_active_o   high while the ball is in play (MOVE)
//   score_l_o       one-clk pulse: left player scored
//   score_r_o       one-clk pulse: right player scored
//
// Optional feature (macro BALL_SPEEDUP_EN): each paddle hit adds one to a
// boost counter that saturates at 3. The step becomes velocity + boost,
// saturating at 7. The boost is cleared whenever the ball is not in play.
// ---------------------------------------------------------------------------
module ball_motion #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PADDLE_X_L   = 16,
    parameter int unsigned PADDLE_X_R   = 616,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic [2:0] ball_velocity_i,
    input  logic [9:0] paddle_l_y_i,
    input  logic [9:0] paddle_r_y_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic       ball_active_o,
    output logic       score_l_o,
    output logic       score_r_o
);

    localparam int unsigned PW  = 10;  // position register width
    localparam int unsigned AW  = 11;  // arithmetic width, one guard bit
    localparam int unsigned SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [PW-1:0]  CX         = PW'((H_RES - BALL_SIZE) / 2);
    localparam logic [PW-1:0]  CY         = PW'((V_RES - BALL_SIZE) / 2);
    localparam logic [AW-1:0]  X_MAX      = AW'(H_RES - BALL_SIZE);
    localparam logic [AW-1:0]  Y_MAX      = AW'(V_RES - BALL_SIZE);
    localparam logic [AW-1:0]  L_FACE     = AW'(PADDLE_X_L + PADDLE_W);
    localparam logic [AW-1:0]  R_FACE     = AW'(PADDLE_X_R);
    localparam logic [AW-1:0]  R_STOP     = AW'(PADDLE_X_R - BALL_SIZE);
    localparam logic [AW-1:0]  BSZ        = AW'(BALL_SIZE);
    localparam logic [AW-1:0]  PHT        = AW'(PADDLE_H);
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERVE  = 2'd1,
        S_MOVE   = 2'd2,
        S_SCORED = 2'd3
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   x_q, y_q;
    logic            dir_left_q, dir_up_q;
    logic [SCW-1:0]  cnt_q;
    logic            score_l_q, score_r_q, active_q;

    // Candidate MOVE-step results for the current position
    logic [PW-1:0]   x_d, y_d;
    logic            dir_left_d, dir_up_d;
    logic            exit_left, exit_right;

    logic [AW-1:0]   x_w, y_w, v_w, pl_w, pr_w;
    logic            overlap_l, overlap_r, vel_zero;

    assign x_w      = AW'(x_q);
    assign y_w      = AW'(y_q);
    assign pl_w     = AW'(paddle_l_y_i);
    assign pr_w     = AW'(paddle_r_y_i);
    assign vel_zero = (ball_velocity_i == 3'd0);

`ifdef BALL_SPEEDUP_EN
    logic [1:0] boost_q;
    logic [3:0] v_sum;
    logic       paddle_hit;

    assign v_sum      = {1'b0, ball_velocity_i} + {2'b00, boost_q};
    assign v_w        = (v_sum > 4'd7) ? AW'(7) : AW'(v_sum);
    // Only a paddle hit flips the horizontal direction
    assign paddle_hit = (dir_left_d != dir_left_q);

    // Boost counter lives only while the ball is in play
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != S_MOVE)) begin
            boost_q <= '0;
        end else if (frame_tick_i && !vel_zero && paddle_hit && (boost_q != 2'd3)) begin
            boost_q <= boost_q + 2'd1;
        end
    end
`else
    assign v_w = AW'(ball_velocity_i);
`endif

    // Vertical overlap uses the pre-step y
    assign overlap_l = ((y_w + BSZ) > pl_w) && (y_w < (pl_w + PHT));
    assign overlap_r = ((y_w + BSZ) > pr_w) && (y_w < (pr_w + PHT));

    // One frame of motion: walls, paddles, and misses
    always_comb begin
        y_d        = y_q;
        dir_up_d   = dir_up_q;
        x_d        = x_q;
        dir_left_d = dir_left_q;
        exit_left  = 1'b0;
        exit_right = 1'b0;

        if (dir_up_q) begin
            if (y_w < v_w) begin
                y_d      = '0;
                dir_up_d = 1'b0;
            end else begin
                y_d = PW'(y_w - v_w);
            end
        end else begin
            if ((y_w + v_w) > Y_MAX) begin
                y_d      = PW'(Y_MAX);
                dir_up_d = 1'b1;
            end else begin
                y_d = PW'(y_w + v_w);
            end
        end

        if (dir_left_q) begin
            if ((x_w >= L_FACE) && ((x_w - v_w) < L_FACE) && overlap_l) begin
                x_d        = PW'(L_FACE);
                dir_left_d = 1'b0;
            end else if (x_w < v_w) begin
                exit_left = 1'b1;
            end else begin
                x_d = PW'(x_w - v_w);
            end
        end else begin
            if (((x_w + BSZ) <= R_FACE) && ((x_w + v_w + BSZ) > R_FACE) && overlap_r) begin
                x_d        = PW'(R_STOP);
                dir_left_d = 1'b1;
            end else if ((x_w + v_w) > X_MAX) begin
                exit_right = 1'b1;
            end else begin
                x_d = PW'(x_w + v_w);
            end
        end
    end

    // Game state machine with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            x_q        <= CX;
            y_q        <= CY;
            dir_left_q <= 1'b0;
            dir_up_q   <= 1'b0;
            cnt_q      <= '0;
            score_l_q  <= 1'b0;
            score_r_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            active_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    x_q   <= CX;
                    y_q   <= CY;
                    cnt_q <= '0;
                    if (!vel_zero) begin
                        state_q <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    x_q <= CX;
                    y_q <= CY;
                    if (vel_zero) begin
                        state_q <= S_IDLE;
                    end else if (frame_tick_i) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_q  <= S_MOVE;
                            active_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + SCW'(1);
                        end
                    end
                end
                S_MOVE: begin
                    if (vel_zero) begin
                        state_q <= S_IDLE;
                        x_q     <= CX;
                        y_q     <= CY;
                    end else if (frame_tick_i && (exit_left || exit_right)) begin
                        // Miss: recentre, serve toward the conceding player
                        state_q    <= S_SCORED;
                        x_q        <= CX;
                        y_q        <= CY;
                        score_r_q  <= exit_left;
                        score_l_q  <= exit_right;
                        dir_left_q <= exit_left;
                    end else begin
                        active_q <= 1'b1;
                        if (frame_tick_i) begin
                            x_q        <= x_d;
                            y_q        <= y_d;
                            dir_left_q <= dir_left_d;
                            dir_up_q   <= dir_up_d;
                        end
                    end
                end
                S_SCORED: begin
                    state_q <= S_SERVE;
                    cnt_q   <= '0;
                    x_q     <= CX;
                    y_q     <= CY;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ball_x_o      = x_q;
    assign ball_y_o      = y_q;
    assign ball_active_o = active_q;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;

endmodule

// File: tb/tb_ball_motion.sv
// ---------------------------------------------------------------------------
// tb_ball_motion: self-checking bench for ball_motion (default build).
// The vector table lists segments of play. Each row sets the velocity and
// paddles, applies N frame ticks, and gives the hand-derived ball state and
// cumulative score-pulse cycle counts. Hand-written sequences then cover
// reset mid-move, disable timing and serve abort.
// ---------------------------------------------------------------------------
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [2:0] vel = 3'd0;
    logic [9:0] pl = 10'd0;
    logic [9:0] pr = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       ball_active, score_l, score_r;

    ball_motion dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .frame_tick_i    (frame_tick),
        .ball_velocity_i (vel),
        .paddle_l_y_i    (pl),
        .paddle_r_y_i    (pr),
        .ball_x_o        (ball_x),
        .ball_y_o        (ball_y),
        .ball_active_o   (ball_active),
        .score_l_o       (score_l),
        .score_r_o       (score_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned vel;
        int unsigned pl;
        int unsigned pr;
        int unsigned ticks;
        int unsigned ex;
        int unsigned ey;
        int unsigned eact;
        int unsigned esl;
        int unsigned esr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int sl_cycles  = 0;
    int sr_cycles  = 0;
    int bad_pulse  = 0;

    // Score pulse monitor: counts high cycles and flags illegal pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (score_l) sl_cycles++;
            if (score_r) sr_cycles++;
            if (score_l && score_r) bad_pulse++;
            if ((score_l || score_r) && ((ball_x != 10'd316) || (ball_y != 10'd236) || ball_active))
                bad_pulse++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic void add(int unsigned v, int unsigned l, int unsigned r, int unsigned t,
                                int unsigned x, int unsigned y, int unsigned a,
                                int unsigned sl, int unsigned sr);
        vec_t e;
        e.vel = v; e.pl = l; e.pr = r; e.ticks = t;
        e.ex = x; e.ey = y; e.eact = a; e.esl = sl; e.esr = sr;
        vecs.push_back(e);
    endfunction

    task automatic check_ball(input string tag, input int unsigned x, input int unsigned y,
                              input int unsigned a);
        check({tag, ".x"}, 32'(ball_x), x);
        check({tag, ".y"}, 32'(ball_y), y);
        check({tag, ".active"}, 32'(ball_active), a);
    endtask

    initial begin
        vec_t e;
        //  vel  pl   pr  ticks   x    y  act sl sr
        add(0,   0,   0, 100,  316, 236, 0, 0, 0);  // idle hold ignores ticks
        add(2,   0,   0,  59,  316, 236, 0, 0, 0);  // still serving
        add(2,   0,   0,   1,  316, 236, 1, 0, 0);  // tick 60 enters MOVE
        add(2,   0,   0,   1,  318, 238, 1, 0, 0);  // first step
        add(2,   0,   0, 116,  550, 470, 1, 0, 0);
        add(3,   0,   0,   1,  553, 472, 1, 0, 0);  // bottom wall clamp
        add(3,   0,   0,   1,  556, 469, 1, 0, 0);  // now moving up
        add(3,   0, 400,   2,  562, 463, 1, 0, 0);
        add(4,   0, 400,  11,  606, 419, 1, 0, 0);
        add(4,   0, 400,   1,  608, 415, 1, 0, 0);  // right paddle hit
        add(4, 150, 400,   1,  604, 411, 1, 0, 0);  // moving left
        add(4, 150, 400, 102,  196,   3, 1, 0, 0);
        add(4, 150, 400,   1,  192,   0, 1, 0, 0);  // top wall clamp
        add(4, 150, 400,   1,  188,   4, 1, 0, 0);
        add(4, 150, 400,  41,   24, 168, 1, 0, 0);
        add(4, 150, 400,   1,   24, 172, 1, 0, 0);  // left paddle hit
        add(4, 150,   0,   1,   28, 176, 1, 0, 0);
        add(4, 150,   0,  73,  320, 468, 1, 0, 0);
        add(4, 150,   0,   1,  324, 472, 1, 0, 0);  // lands exactly on 472
        add(4, 150,   0,   1,  328, 472, 1, 0, 0);  // bounce from 472
        add(4, 150,   0,   1,  332, 468, 1, 0, 0);
        add(4, 150,   0,  75,  632, 168, 1, 0, 0);  // rightmost legal x
        add(4, 150,   0,   1,  316, 236, 0, 1, 0);  // right miss
        add(4, 150,   0,  60,  316, 236, 1, 1, 0);
        add(4, 150,   0,   1,  320, 232, 1, 1, 0);  // serves right
        add(4,   0,  40,  72,  608,  52, 1, 1, 0);
        add(4,   0,  40,   1,  608,  56, 1, 1, 0);  // right paddle hit
        add(4,   0,  40,   1,  604,  60, 1, 1, 0);
        add(4,   0,  40, 151,    0, 284, 1, 1, 0);  // passes left paddle
        add(4,   0,  40,   1,  316, 236, 0, 1, 1);  // left miss
        add(4,   0,   0,  60,  316, 236, 1, 1, 1);
        add(4,   0,   0,   1,  312, 232, 1, 1, 1);  // serves left
        add(0,   0,   0,   0,  316, 236, 0, 1, 1);  // disable mid-move

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ball("reset", 316, 236, 0);
        check("reset.score_l", 32'(score_l), 0);
        check("reset.score_r", 32'(score_r), 0);

        foreach (vecs[i]) begin
            vel = 3'(vecs[i].vel);
            pl  = 10'(vecs[i].pl);
            pr  = 10'(vecs[i].pr);
            sb_q.push_back(vecs[i]);
            repeat (2) @(negedge clk);
            repeat (vecs[i].ticks) do_tick();
            e = sb_q.pop_front();
            check_ball($sformatf("v%0d", i), e.ex, e.ey, e.eact);
            check($sformatf("v%0d.sl_cycles", i), 32'(sl_cycles), e.esl);
            check($sformatf("v%0d.sr_cycles", i), 32'(sr_cycles), e.esr);
        end

        // Reset mid-move: directions were left/up before the reset
        vel = 3'd1;
        repeat (2) @(negedge clk);
        repeat (65) do_tick();
        check_ball("pre_rst", 311, 231, 1);
        rst = 1'b1;
        @(negedge clk);
        check_ball("mid_rst", 316, 236, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        repeat (60) do_tick();
        check_ball("rst_serve", 316, 236, 1);
        do_tick();
        check_ball("rst_dir", 317, 237, 1);

        // Disable recentres on the very next cycle
        vel = 3'd0;
        @(negedge clk);
        check_ball("dis_next", 316, 236, 0);

        // Dropping velocity during serve restarts the serve count
        vel = 3'd3;
        repeat (2) @(negedge clk);
        repeat (30) do_tick();
        vel = 3'd0;
        repeat (2) @(negedge clk);
        vel = 3'd3;
        repeat (2) @(negedge clk);
        repeat (59) do_tick();
        check_ball("abort59", 316, 236, 0);
        do_tick();
        check_ball("abort60", 316, 236, 1);
        do_tick();
        check_ball("abort_step", 319, 239, 1);

        check("pulse_rules", 32'(bad_pulse), 0);
        check("final.sl_cycles", 32'(sl_cycles), 1);
        check("final.sr_cycles", 32'(sr_cycles), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
